// File: rtl/conv_pkg.sv
// conv_pkg: shared state encoding and accumulator sizing for the convolution engine
package conv_pkg;
   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_CAPTURE = 3'd1,
      ST_COMPUTE = 3'd2,
      ST_DISPLAY = 3'd3,
      ST_DONE    = 3'd4
   } state_e;
   function automatic int acc_w(input int data_w, input int taps);
      return 2 * data_w + $clog2(taps);
   endfunction
endpackage

// File: rtl/conv_mac.sv
// conv_mac: unsigned multiply-accumulate; sum is the value the accumulator takes on the next enabled edge
module conv_mac
   import conv_pkg::*;
#(
   parameter int DATA_W = 8,
   parameter int ACC_W  = acc_w(8, 9)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              clr,
   input  logic              en,
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] b,
   output logic [ACC_W-1:0]  sum
);
   logic [ACC_W-1:0] acc;
   assign sum = acc + ACC_W'(a) * ACC_W'(b);
   // clear has priority so the finishing tap can hand off its sum and restart at zero
   always_ff @(posedge clk)
      if (!reset || clr) acc <= '0;
      else if (en) acc <= sum;
endmodule

// File: rtl/conv_engine_param.sv
// conv_engine_param: N x N by K x K valid convolution on one sequential MAC, results streamed for display
// Define CONV_SATURATE_EN to clamp results to OUT_W bits instead of wrapping.
module conv_engine_param
   import conv_pkg::*;
#(
   parameter int N         = 4,
   parameter int K         = 3,
   parameter int DATA_W    = 8,
   parameter int OUT_W     = 8,
   parameter int DISP_HOLD = 1,
   localparam int M        = N - K + 1,
   localparam int MM       = M * M,
   localparam int IDX_W    = (MM > 1) ? $clog2(MM) : 1
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       run,
   input  logic [N*N*DATA_W-1:0]      a_flat,
   input  logic [K*K*DATA_W-1:0]      b_flat,
   output logic                       busy,
   output logic                       done,
   output logic                       result_valid,
   output logic [OUT_W-1:0]           result,
   output logic [IDX_W-1:0]           result_idx,
   output logic [2:0]                 state
);
   localparam int ACC_W = acc_w(DATA_W, K * K);
   localparam int CW    = $clog2(N) + 1;
   localparam int HW    = $clog2(DISP_HOLD) + 1;
   localparam logic [CW-1:0] K_LAST = CW'(K - 1);
   localparam logic [CW-1:0] M_LAST = CW'(M - 1);
   state_e                  st;
   logic [N*N*DATA_W-1:0]   a_q;
   logic [K*K*DATA_W-1:0]   b_q;
   logic [CW-1:0]           out_r, out_c, tap_r, tap_c;
   logic [IDX_W-1:0]        disp_idx, wr_idx;
   logic [HW-1:0]           hold;
   logic [OUT_W-1:0]        rbuf [MM];
   logic [DATA_W-1:0]       a_op, b_op;
   logic [ACC_W-1:0]        sum;
   logic [OUT_W-1:0]        res_in;
   logic                    last_tap, last_out, mac_clr;

   // operand selection for the current output/tap position and conversion of the finished sum
   always_comb begin
      a_op     = DATA_W'(a_q >> ((int'(out_r + tap_r) * N + int'(out_c + tap_c)) * DATA_W));
      b_op     = DATA_W'(b_q >> ((int'(tap_r) * K + int'(tap_c)) * DATA_W));
      wr_idx   = IDX_W'(int'(out_r) * M + int'(out_c));
      last_tap = tap_r == K_LAST && tap_c == K_LAST;
      last_out = out_r == M_LAST && out_c == M_LAST;
      mac_clr  = st == ST_CAPTURE || (st == ST_COMPUTE && last_tap);
`ifdef CONV_SATURATE_EN
      res_in   = ((sum >> OUT_W) != '0) ? '1 : OUT_W'(sum);
`else
      res_in   = OUT_W'(sum);
`endif
   end

   conv_mac #(.DATA_W(DATA_W), .ACC_W(ACC_W)) u_mac (
      .clk   (clk),
      .reset (reset),
      .clr   (mac_clr),
      .en    (st == ST_COMPUTE),
      .a     (a_op),
      .b     (b_op),
      .sum   (sum)
   );

   // sequencer: capture, walk taps within each output position, then step through the buffer
   always_ff @(posedge clk) begin
      if (!reset) begin
         st       <= ST_IDLE;
         a_q      <= '0;
         b_q      <= '0;
         out_r    <= '0;
         out_c    <= '0;
         tap_r    <= '0;
         tap_c    <= '0;
         disp_idx <= '0;
         hold     <= '0;
         for (int i = 0; i < MM; i++) rbuf[i] <= '0;
      end else begin
         case (st)
            ST_IDLE: if (run) st <= ST_CAPTURE;
            ST_CAPTURE: begin
               a_q      <= a_flat;
               b_q      <= b_flat;
               out_r    <= '0;
               out_c    <= '0;
               tap_r    <= '0;
               tap_c    <= '0;
               disp_idx <= '0;
               hold     <= '0;
               st       <= ST_COMPUTE;
            end
            ST_COMPUTE: begin
               tap_c <= (tap_c == K_LAST) ? '0 : tap_c + 1'b1;
               if (tap_c == K_LAST) tap_r <= (tap_r == K_LAST) ? '0 : tap_r + 1'b1;
               if (last_tap) begin
                  rbuf[wr_idx] <= res_in;
                  out_c        <= (out_c == M_LAST) ? '0 : out_c + 1'b1;
                  if (out_c == M_LAST) out_r <= last_out ? '0 : out_r + 1'b1;
                  if (last_out) st <= ST_DISPLAY;
               end
            end
            ST_DISPLAY: begin
               hold <= (hold == HW'(DISP_HOLD - 1)) ? '0 : hold + 1'b1;
               if (hold == HW'(DISP_HOLD - 1)) begin
                  if (disp_idx == IDX_W'(MM - 1)) st <= ST_DONE;
                  else disp_idx <= disp_idx + 1'b1;
               end
            end
            ST_DONE: st <= ST_IDLE;
            default: st <= ST_IDLE;
         endcase
      end
   end

   assign busy         = st != ST_IDLE;
   assign done         = st == ST_DONE;
   assign result_valid = st == ST_DISPLAY;
   assign result       = result_valid ? rbuf[disp_idx] : '0;
   assign result_idx   = result_valid ? disp_idx : '0;
   assign state        = st;
endmodule

// File: tb/tb_conv_engine_param.sv
// tb_conv_engine_param: randomized bench with a timeline model of the engine plus literal pins
module tb_conv_engine_param;
   localparam int N = 4, K = 3, DW = 8, M = 2, MM = 4, CK = 36;
   localparam int LAST = CK + MM + 1;
   logic                clk = 0, reset = 0, run = 0, run2 = 0;
   logic [N*N*DW-1:0]   a_flat = '0;
   logic [K*K*DW-1:0]   b_flat = '0;
   logic                busy, done, result_valid;
   logic [7:0]          result;
   logic [1:0]          result_idx;
   logic [2:0]          state;
   logic [5*5*8-1:0]    a2 = '0;
   logic [2*2*8-1:0]    b2 = '0;
   logic                busy2, done2, rv2;
   logic [7:0]          res2;
   logic [3:0]          idx2;
   logic [2:0]          st2;
   int                  n_chk = 0, n_fail = 0;
   int                  ph = -1;
   int                  exp_r [MM];
   int                  seen [$];

   conv_engine_param u_dut (
      .clk(clk), .reset(reset), .run(run), .a_flat(a_flat), .b_flat(b_flat),
      .busy(busy), .done(done), .result_valid(result_valid), .result(result),
      .result_idx(result_idx), .state(state)
   );

   conv_engine_param #(.N(5), .K(2), .DISP_HOLD(3)) u_dut2 (
      .clk(clk), .reset(reset), .run(run2), .a_flat(a2), .b_flat(b2),
      .busy(busy2), .done(done2), .result_valid(rv2), .result(res2),
      .result_idx(idx2), .state(st2)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   function automatic int conv_at(input int r, input int c);
      longint s = 0;
      for (int i = 0; i < K; i++)
         for (int j = 0; j < K; j++)
            s += longint'(a_flat[((r + i) * N + c + j) * DW +: DW]) * longint'(b_flat[(i * K + j) * DW +: DW]);
`ifdef CONV_SATURATE_EN
      return (s > 255) ? 255 : int'(s);
`else
      return int'(s % 256);
`endif
   endfunction

   // ph: -1 idle, else cycles since the run-sampling edge (0 capture, 1..CK compute, then display, then done)
   always @(posedge clk) begin
      if (!reset) ph = -1;
      else if (ph == -1) ph = run ? 0 : -1;
      else begin
         if (ph == 0)
            for (int r = 0; r < M; r++)
               for (int c = 0; c < M; c++) exp_r[r * M + c] = conv_at(r, c);
         ph = (ph == LAST) ? -1 : ph + 1;
      end
   end

   always @(negedge clk) begin
      int es, ix;
      es = (ph < 0) ? 0 : (ph == 0) ? 1 : (ph <= CK) ? 2 : (ph <= CK + MM) ? 3 : 4;
      ix = (es == 3) ? ph - CK - 1 : 0;
      chk("state", state, es);
      chk("busy", busy, es != 0);
      chk("done", done, es == 4);
      chk("valid", result_valid, es == 3);
      chk("idx", result_idx, ix);
      chk("result", result, (es == 3) ? exp_r[ix] : 0);
      if (result_valid) seen.push_back(int'(result));
   end

   task automatic start();
      @(posedge clk); #1 run = 1;
      @(posedge clk); #1 run = 0;
   endtask

   task automatic wait_done();
      for (int i = 0; i < 200 && done !== 1'b1; i++) @(negedge clk);
      chk("done_seen", done, 1);
      @(negedge clk);
   endtask

   task automatic check_seen(input string nm, input int e0, input int e1, input int e2, input int e3);
      int e [4];
      e = '{e0, e1, e2, e3};
      chk({nm, "_count"}, seen.size(), 4);
      for (int i = 0; i < 4 && i < seen.size(); i++) chk(nm, seen[i], e[i]);
   endtask

   task automatic fill(input int av, input int bv);
      for (int i = 0; i < N * N; i++) a_flat[i * DW +: DW] = 8'(av);
      for (int i = 0; i < K * K; i++) b_flat[i * DW +: DW] = 8'(bv);
   endtask

   task automatic seq_a_centre();
      for (int i = 0; i < N * N; i++) a_flat[i * DW +: DW] = 8'(i + 1);
      b_flat = '0;
      b_flat[4 * DW +: DW] = 8'd1;
   endtask

   initial begin
      int lat, t_first, t_second;
      repeat (3) @(posedge clk);
      #1 reset = 1;
      @(negedge clk);
      chk("reset_state", state, 0);
      chk("reset_result", result, 0);
      fill(1, 1);
      seen.delete();
      start();
      lat = 0;
      for (int i = 0; i < 100 && result_valid !== 1'b1; i++) begin
         @(negedge clk);
         lat++;
      end
      chk("first_valid_latency", lat, 38);
      wait_done();
      check_seen("ones", 9, 9, 9, 9);
      seq_a_centre();
      seen.delete();
      start();
      wait_done();
      check_seen("centre", 6, 7, 10, 11);
      fill(255, 255);
      seen.delete();
      start();
      wait_done();
`ifdef CONV_SATURATE_EN
      check_seen("sat", 255, 255, 255, 255);
`else
      check_seen("wrap", 9, 9, 9, 9);
`endif
      seq_a_centre();
      seen.delete();
      start();
      repeat (5) @(posedge clk);
      #1 run = 1;
      for (int i = 0; i < N * N; i++) a_flat[i * DW +: DW] = 8'($urandom);
      repeat (2) @(posedge clk);
      #1 run = 0;
      wait_done();
      check_seen("ignore_run", 6, 7, 10, 11);
      fill(1, 1);
      start();
      for (int i = 0; i < 10 && state !== 3'd2; i++) @(negedge clk);
      repeat (9) @(negedge clk);
      reset = 0;
      @(negedge clk);
      chk("rst_mid_state", state, 0);
      chk("rst_mid_busy", busy, 0);
      chk("rst_mid_valid", result_valid, 0);
      chk("rst_mid_done", done, 0);
      reset = 1;
      for (int i = 0; i < N * N; i++) a_flat[i * DW +: DW] = 8'($urandom);
      for (int i = 0; i < K * K; i++) b_flat[i * DW +: DW] = 8'($urandom);
      seen.delete();
      start();
      wait_done();
      chk("after_reset_count", seen.size(), 4);
      for (int n = 0; n < 4; n++) begin
         for (int i = 0; i < N * N; i++) a_flat[i * DW +: DW] = 8'($urandom);
         for (int i = 0; i < K * K; i++) b_flat[i * DW +: DW] = 8'($urandom_range(0, 3) == 0 ? 255 : $urandom);
         start();
         wait_done();
      end
      fill(2, 3);
      @(posedge clk); #1 run = 1;
      t_first = 0;
      for (int i = 0; i < 200 && done !== 1'b1; i++) begin
         @(negedge clk);
         t_first++;
      end
      t_second = 0;
      @(negedge clk);
      for (int i = 0; i < 200 && done !== 1'b1; i++) begin
         @(negedge clk);
         t_second++;
      end
      run = 0;
      chk("restart_gap", t_second + 1, 43);
      repeat (3) @(negedge clk);
      for (int i = 0; i < 5 * 5; i++) a2[i * 8 +: 8] = 8'd1;
      for (int i = 0; i < 2 * 2; i++) b2[i * 8 +: 8] = 8'd1;
      @(posedge clk); #1 run2 = 1;
      @(posedge clk); #1 run2 = 0;
      lat = 0;
      for (int i = 0; i < 300 && rv2 !== 1'b1; i++) begin
         @(negedge clk);
         lat++;
      end
      chk("p2_first_valid_latency", lat, 66);
      for (int k = 0; k < 48; k++) begin
         chk("p2_valid", rv2, 1);
         chk("p2_idx", idx2, k / 3);
         chk("p2_result", res2, 4);
         @(negedge clk);
      end
      chk("p2_valid_end", rv2, 0);
      chk("p2_done", done2, 1);
      @(negedge clk);
      chk("p2_idle", st2, 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
